// File: rtl/rns_pkg.sv
// Shared definitions for the RNS command sequencer and its operand demux.
package rns_pkg;

    localparam int W_DEFAULT = 7;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    // s1s0 code that makes the result network output zero
    localparam logic [1:0] SEL_ZERO = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Select code seen by the result network: the opcode while a unit is busy, zero otherwise
    function automatic logic [1:0] sel_code(input logic en, input logic [1:0] op);
        return en ? op : SEL_ZERO;
    endfunction

endpackage

// File: rtl/rns_operand_demux.sv
// Routes the latched operand pair to exactly one residue unit; the other two
// pairs are held at zero because the result network ORs in the add term whenever s0=0.
module rns_operand_demux
    import rns_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         i_en,
    input  logic [1:0]   i_op,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_add_a,
    output logic [W-1:0] o_add_b,
    output logic [W-1:0] o_sub_a,
    output logic [W-1:0] o_sub_b,
    output logic [W-1:0] o_mul_a,
    output logic [W-1:0] o_mul_b
);

    // Steer a/b to the selected unit only; everything else reads zero
    always_comb begin
        o_add_a = '0;
        o_add_b = '0;
        o_sub_a = '0;
        o_sub_b = '0;
        o_mul_a = '0;
        o_mul_b = '0;
        if (i_en) begin
            case (i_op)
                OP_ADD: begin
                    o_add_a = i_a;
                    o_add_b = i_b;
                end
                OP_SUB: begin
                    o_sub_a = i_a;
                    o_sub_b = i_b;
                end
                OP_MUL: begin
                    o_mul_a = i_a;
                    o_mul_b = i_b;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rns_op_sequencer.sv
// Command front end of the RNS datapath: accepts one op, drives the selected
// residue unit for its latency, captures the network result and returns it.
//
// state | meaning
// IDLE  | ready for a command, units idle, network forced to zero
// EXEC  | selected unit driven, latency counter running down to zero
// RESP  | response held on rsp_* until the consumer takes it
module rns_op_sequencer
    import rns_pkg::*;
#(
    parameter int W       = W_DEFAULT,
    parameter int ADD_LAT = 1,
    parameter int SUB_LAT = 1,
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    output logic [W-1:0] sub_a,
    output logic [W-1:0] sub_b,
    output logic [W-1:0] mul_a,
    output logic [W-1:0] mul_b,
    output logic         s0,
    output logic         s1,
    input  logic [W-1:0] mux_result,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_err
);

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_op;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_rsp_data;
    logic             r_rsp_err;
    logic [CNT_W-1:0] w_lat_m1;
    logic             w_accept;
    logic             w_exec;

    assign w_accept = cmd_valid & cmd_ready;

    // Counter preload: the count reaches zero in the last EXEC cycle, so EXEC lasts LAT cycles
    always_comb begin
        w_lat_m1 = '0;
        case (cmd_op)
            OP_ADD:  w_lat_m1 = CNT_W'(ADD_LAT - 1);
            OP_SUB:  w_lat_m1 = CNT_W'(SUB_LAT - 1);
            OP_MUL:  w_lat_m1 = CNT_W'(MUL_LAT - 1);
            default: w_lat_m1 = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; illegal opcodes skip EXEC and report straight away
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = (cmd_op == OP_ILL) ? RESP : EXEC;
                end
            end
            EXEC: begin
                if (r_cnt == '0) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Command latch, latency counter and response capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op       <= OP_ADD;
            r_a        <= '0;
            r_b        <= '0;
            r_cnt      <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= cmd_op;
                r_a   <= cmd_a;
                r_b   <= cmd_b;
                r_cnt <= w_lat_m1;
                if (cmd_op == OP_ILL) begin
                    r_rsp_data <= '0;
                    r_rsp_err  <= 1'b1;
                end
            end
            if (r_state == EXEC) begin
                if (r_cnt == '0) begin
                    r_rsp_data <= mux_result;
                    r_rsp_err  <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    // Outputs decoded from state; cmd_ready is also held low while reset is asserted
    always_comb begin
        cmd_ready = (r_state == IDLE) && rst_n;
        rsp_valid = (r_state == RESP);
        w_exec    = (r_state == EXEC);
        {s1, s0}  = sel_code(w_exec, r_op);
    end

    assign rsp_data = r_rsp_data;
    assign rsp_err  = r_rsp_err;

    rns_operand_demux #(.W(W)) u_demux (
        .i_en    (w_exec),
        .i_op    (r_op),
        .i_a     (r_a),
        .i_b     (r_b),
        .o_add_a (add_a),
        .o_add_b (add_b),
        .o_sub_a (sub_a),
        .o_sub_b (sub_b),
        .o_mul_a (mul_a),
        .o_mul_b (mul_b)
    );

endmodule
